// File: rtl/l2_spram_pkg.sv
// Shared constants and types for the single-port RAM with stall and response queue.
package l2_spram_pkg;

    localparam int unsigned LFSR_W = 16;

    // Fibonacci LFSR seed and tap mask (taps 16,14,13,11 -> bits 15,13,12,10)
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    localparam int unsigned FIFO_DEPTH_DEF = 4;

    localparam int unsigned RESP_DATA_W = 32;
    localparam int unsigned RESP_ID_W   = 3;
    localparam int unsigned RESP_AUX_W  = 4;

    // Response payload at the default widths; the top rebuilds it at its own widths
    typedef struct packed {
        logic [RESP_DATA_W-1:0] data;
        logic [RESP_ID_W-1:0]   id;
        logic [RESP_AUX_W-1:0]  aux;
    } resp_t;

    // One Fibonacci step: shift left, feedback is the parity of the tapped bits
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/l2_spram_resp_fifo.sv
// In-order response queue; head reads as zero when empty.
module l2_spram_resp_fifo
    import l2_spram_pkg::*;
#(
    parameter type         entry_t = resp_t,
    parameter int unsigned DEPTH   = FIFO_DEPTH_DEF
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  logic   pop,
    input  entry_t din,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    entry_t          store [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : store[rd_ptr];

    // Payload storage, no reset needed since the head is masked while empty
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            store[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/l2_spram_stall.sv
// Byte-enabled single-port RAM with a grant handshake and an in-order response queue.
// Define L2_SPRAM_RANDOM_STALL_EN to insert LFSR-driven random grant stalls.
module l2_spram_stall
    import l2_spram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned AUX_WIDTH  = 4,
    parameter int unsigned ID_WIDTH   = 3,
    parameter int unsigned MEM_AW     = 10,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  CEN,
    input  logic                  WEN,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic [BE_WIDTH-1:0]   BE,
    input  logic [ID_WIDTH-1:0]   id_i,
    input  logic [AUX_WIDTH-1:0]  aux_i,
    output logic                  gnt_o,
    output logic                  r_valid_o,
    output logic [DATA_WIDTH-1:0] Q,
    output logic [ID_WIDTH-1:0]   r_id_o,
    output logic [AUX_WIDTH-1:0]  r_aux_o,
    input  logic                  r_gnt_i
);

    localparam int unsigned WORDS = 2 ** MEM_AW;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ID_WIDTH-1:0]   id;
        logic [AUX_WIDTH-1:0]  aux;
    } rsp_t;

    logic [DATA_WIDTH-1:0] mem [WORDS];
    logic [MEM_AW-1:0]     widx;
    logic                  accept;
    logic                  stall;
    logic                  fifo_full;
    logic                  fifo_empty;
    rsp_t                  push_rsp;
    rsp_t                  head_rsp;
    logic                  unused_addr;

    // Upper address bits and byte offset do not select a word
    assign widx        = A[MEM_AW+1:2];
    assign unused_addr = ^{A[ADDR_WIDTH-1:MEM_AW+2], A[1:0]};

    assign gnt_o  = !fifo_full && !stall;
    assign accept = !CEN && gnt_o;

`ifdef L2_SPRAM_RANDOM_STALL_EN
    logic [LFSR_W-1:0] lfsr;

    // Free-running stall generator, stalls when the two low bits are zero
    always_ff @(posedge CLK) begin
        if (RSTN) lfsr <= LFSR_SEED;
        else      lfsr <= lfsr_next(lfsr);
    end

    assign stall = (lfsr[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // Byte-masked store; loads see the pre-write word through the response path
    always_ff @(posedge CLK) begin
        if (!RSTN && accept && !WEN) begin
            for (int k = 0; k < int'(BE_WIDTH); k++) begin
                if (BE[k]) mem[widx][8*k +: 8] <= D[8*k +: 8];
            end
        end
    end

    // Every accepted request produces one response; stores return zero data
    always_comb begin
        push_rsp      = '0;
        push_rsp.data = WEN ? mem[widx] : '0;
        push_rsp.id   = id_i;
        push_rsp.aux  = aux_i;
    end

    l2_spram_resp_fifo #(
        .entry_t (rsp_t),
        .DEPTH   (FIFO_DEPTH)
    ) u_resp_fifo (
        .clk   (CLK),
        .rst   (RSTN),
        .push  (accept),
        .pop   (r_gnt_i),
        .din   (push_rsp),
        .head  (head_rsp),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign r_valid_o = !fifo_empty;
    assign Q         = head_rsp.data;
    assign r_id_o    = head_rsp.id;
    assign r_aux_o   = head_rsp.aux;

endmodule

// File: tb/tb_l2_spram_stall.sv
// Scoreboard bench for l2_spram_stall (default parameters).
module tb_l2_spram_stall;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b1;
    logic        CEN = 1'b1;
    logic        WEN = 1'b1;
    logic [31:0] A = '0;
    logic [31:0] D = '0;
    logic [3:0]  BE = '0;
    logic [2:0]  id_i = '0;
    logic [3:0]  aux_i = '0;
    logic        gnt_o;
    logic        r_valid_o;
    logic [31:0] Q;
    logic [2:0]  r_id_o;
    logic [3:0]  r_aux_o;
    logic        r_gnt_i = 1'b1;

    l2_spram_stall dut (
        .CLK(CLK), .RSTN(RSTN), .CEN(CEN), .WEN(WEN), .A(A), .D(D), .BE(BE),
        .id_i(id_i), .aux_i(aux_i), .gnt_o(gnt_o), .r_valid_o(r_valid_o),
        .Q(Q), .r_id_o(r_id_o), .r_aux_o(r_aux_o), .r_gnt_i(r_gnt_i)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] q;
        logic [2:0]  id;
        logic [3:0]  aux;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] mdl [1024];
    int          tests = 0;
    int          errors = 0;
    int          rg_mode = 0;   // 0: always accept, 1: random, 2: manual
    bit          in_reset = 1'b1;
    bit          done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: word index from byte address, stores answer zero, loads answer the old word
    task automatic model_accept(input logic wen, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] be, input logic [2:0] id, input logic [3:0] aux);
        int   idx;
        exp_t e;
        idx   = int'((a >> 2) % 1024);
        e.id  = id;
        e.aux = aux;
        e.q   = wen ? mdl[idx] : 32'h0;
        expq.push_back(e);
        if (!wen) begin
            for (int k = 0; k < 4; k++)
                if (be[k]) mdl[idx][8*k +: 8] = d[8*k +: 8];
        end
    endtask

    task automatic issue(input logic wen, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic [2:0] id, input logic [3:0] aux);
        int n;
        n = 0;
        @(negedge CLK);
        CEN = 1'b0; WEN = wen; A = a; D = d; BE = be; id_i = id; aux_i = aux;
        #1;
        while (!gnt_o && n < 100) begin
            @(negedge CLK); #1; n++;
        end
        if (gnt_o) begin
            model_accept(wen, a, d, be, id, aux);
            @(posedge CLK);
        end else begin
            tests++; errors++;
            $display("FAIL grant_timeout: no grant after %0d cycles", n);
            CEN = 1'b1;
        end
    endtask

    task automatic idle();
        @(negedge CLK);
        CEN = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge CLK);
        CEN = 1'b1;
        rg_mode = 0;
        while (expq.size() != 0 && n < 200) begin
            @(negedge CLK); n++;
        end
        check("drain_left", 64'(expq.size()), 64'd0);
    endtask

    // Consumer handshake driver
    initial forever begin
        @(negedge CLK);
        case (rg_mode)
            0:       r_gnt_i = 1'b1;
            1:       r_gnt_i = 1'($urandom_range(0, 1));
            default: ;
        endcase
    end

    // Monitor: compare presented head with scoreboard; pop on handshake
    initial forever begin
        @(negedge CLK);
        #2;
        if (!in_reset && !done) begin
            if (r_valid_o) begin
                if (expq.size() == 0) begin
                    tests++; errors++;
                    $display("FAIL unexpected_resp: Q=0x%0h id=%0d with empty scoreboard", Q, r_id_o);
                end else begin
                    check("resp_q",   64'(Q),       64'(expq[0].q));
                    check("resp_id",  64'(r_id_o),  64'(expq[0].id));
                    check("resp_aux", 64'(r_aux_o), 64'(expq[0].aux));
                    if (r_gnt_i) void'(expq.pop_front());
                end
            end else begin
                check("idle_zero", 64'({Q, r_id_o, r_aux_o}), 64'd0);
            end
        end
    end

    initial begin
        int low_cnt;
        logic        w;
        logic [31:0] a;

        // Reset
        repeat (3) @(negedge CLK);
        RSTN = 1'b0;
        #1;
        check("rst_valid", 64'(r_valid_o), 64'd0);
        check("rst_gnt",   64'(gnt_o),     64'd1);
        check("rst_q",     64'(Q),         64'd0);
        in_reset = 1'b0;

        // Store then load same word
        issue(1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 3'd2, 4'd5);
        issue(1'b1, 32'h10, 32'h0, 4'h0, 3'd3, 4'd6);
        idle();
        drain();

        // Partial byte-enable write
        issue(1'b0, 32'h20, 32'hFFFFFFFF, 4'hF, 3'd1, 4'd1);
        issue(1'b0, 32'h20, 32'h12345678, 4'b0011, 3'd1, 4'd2);
        issue(1'b1, 32'h20, 32'h0, 4'h0, 3'd4, 4'd3);
        idle();
        drain();
        check("be_word", 64'(mdl[8]), 64'hFFFF5678);

        // Aliasing of upper address bits
        issue(1'b1, 32'h1000_0010, 32'h0, 4'h0, 3'd5, 4'd7);
        issue(1'b0, 32'hF000_0013, 32'hCAFEF00D, 4'hF, 3'd6, 4'd8);
        issue(1'b1, 32'h10, 32'h0, 4'h0, 3'd7, 4'd9);
        idle();
        drain();

`ifndef L2_SPRAM_RANDOM_STALL_EN
        // Back-pressure: four loads fill the queue, fifth is refused
        rg_mode = 2;
        @(negedge CLK);
        r_gnt_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge CLK);
            CEN = 1'b0; WEN = 1'b1; A = 32'h10; id_i = 3'(i); aux_i = 4'(i);
            #1;
            check($sformatf("full_gnt%0d", i), 64'(gnt_o), (i < 4) ? 64'd1 : 64'd0);
            if (i < 4 && gnt_o) model_accept(1'b1, 32'h10, 32'h0, 4'h0, 3'(i), 4'(i));
        end
        @(negedge CLK);
        CEN = 1'b1; r_gnt_i = 1'b1;
        #1;
        check("full_pop_gnt", 64'(gnt_o), 64'd0);
        @(negedge CLK);
        r_gnt_i = 1'b0;
        #1;
        check("after_pop_gnt", 64'(gnt_o), 64'd1);
        drain();
`endif

        // Reset with pending responses; memory must survive
        rg_mode = 2;
        @(negedge CLK);
        r_gnt_i = 1'b0;
        issue(1'b1, 32'h10, 32'h0, 4'h0, 3'd1, 4'd1);
        issue(1'b1, 32'h20, 32'h0, 4'h0, 3'd2, 4'd2);
        issue(1'b1, 32'h30, 32'h0, 4'h0, 3'd3, 4'd3);
        @(negedge CLK);
        CEN = 1'b1;
        in_reset = 1'b1;
        RSTN = 1'b1;
        @(negedge CLK);
        RSTN = 1'b0;
        expq.delete();
        #1;
        check("rst2_valid", 64'(r_valid_o), 64'd0);
        check("rst2_q",     64'(Q),         64'd0);
        in_reset = 1'b0;
        rg_mode = 0;
        issue(1'b1, 32'h10, 32'h0, 4'h0, 3'd4, 4'd4);
        idle();
        drain();

        // Fill words 0..31 with known data
        for (int i = 0; i < 32; i++)
            issue(1'b0, 32'(i * 4), $urandom, 4'hF, 3'($urandom), 4'($urandom));
        idle();
        drain();

        // Continuous requests, consumer always ready: measure refusal rate
        low_cnt = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge CLK);
            w = 1'($urandom_range(0, 1));
            a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 31) << 2) | 32'($urandom_range(0, 3));
            CEN = 1'b0; WEN = w; A = a; D = $urandom; BE = 4'($urandom);
            id_i = 3'($urandom); aux_i = 4'($urandom);
            #1;
            if (gnt_o) model_accept(w, a, D, BE, id_i, aux_i);
            else       low_cnt++;
        end
        idle();
        drain();
`ifdef L2_SPRAM_RANDOM_STALL_EN
        check("stall_rate_ok", 64'((low_cnt >= 150) && (low_cnt <= 350)), 64'd1);
`else
        check("no_stall", 64'(low_cnt), 64'd0);
`endif

        // Random requests with random consumer back-pressure
        rg_mode = 1;
        for (int c = 0; c < 1500; c++) begin
            @(negedge CLK);
            w = 1'($urandom_range(0, 1));
            a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 31) << 2) | 32'($urandom_range(0, 3));
            CEN = ($urandom_range(0, 4) == 0);
            WEN = w; A = a; D = $urandom; BE = 4'($urandom);
            id_i = 3'($urandom); aux_i = 4'($urandom);
            #1;
            if (!CEN && gnt_o) model_accept(w, a, D, BE, id_i, aux_i);
        end
        idle();
        drain();

        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/l2_spram_stall.md
L2_SPRAM_STALL -- requirements
Module: l2_spram_stall

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte-address width of A.
REQ-003 SHALL have parameter BE_WIDTH, default DATA_WIDTH/8, byte-enable width.
REQ-004 SHALL have parameter AUX_WIDTH, default 4, width of the aux sideband.
REQ-005 SHALL have parameter ID_WIDTH, default 3, width of the ID sideband.
REQ-006 SHALL have parameter MEM_AW, default 10, log2 of the word depth.
REQ-007 SHALL have parameter FIFO_DEPTH, default 4, response queue entries.
REQ-008 SHALL have port CLK, input, 1, the single clock; all logic is on the rising edge.
REQ-009 SHALL have port RSTN, input, 1, synchronous active-high reset (1 = reset), sampled on the CLK rising edge.
REQ-010 SHALL have port CEN, input, 1, request when low (active-low chip enable).
REQ-011 SHALL have port WEN, input, 1: 0 = store, 1 = load.
REQ-012 SHALL have ports A (input, ADDR_WIDTH), D (input, DATA_WIDTH) and BE (input, BE_WIDTH): byte address, write data and byte enables.
REQ-013 SHALL have ports id_i (input, ID_WIDTH) and aux_i (input, AUX_WIDTH): request sidebands.
REQ-014 SHALL have port gnt_o, output, 1, request accepted this cycle.
REQ-015 SHALL have ports r_valid_o (output, 1), Q (output, DATA_WIDTH), r_id_o (output, ID_WIDTH) and r_aux_o (output, AUX_WIDTH): the response.
REQ-016 SHALL have port r_gnt_i, input, 1, consumer accepts the response.

Function
REQ-017 SHALL store 2**MEM_AW words; word index = A[MEM_AW+1:2]; upper address bits and A[1:0] are ignored.
REQ-018 SHALL form accept = !CEN && gnt_o; only accepted requests have any effect.
REQ-019 SHALL drive gnt_o combinationally as !fifo_full && !stall, where stall is defined in REQ-028.
REQ-020 SHALL, on an accepted store, write byte k only where BE[k]=1, and push a response {Q=0, id_i, aux_i}.
REQ-021 SHALL, on an accepted load, push a response {Q=memory word before any same-cycle write, id_i, aux_i}.
REQ-022 SHALL give every accepted request, load or store, exactly one response, returned in acceptance order.
REQ-023 SHALL drive r_valid_o = fifo not empty, with Q, r_id_o and r_aux_o taken from the FIFO head; minimum latency is 1 cycle (accept at edge t gives r_valid_o high after edge t).
REQ-024 SHALL pop the head when r_valid_o && r_gnt_i; head outputs SHALL stay stable while r_valid_o=1 and r_gnt_i=0.
REQ-025 SHALL allow push and pop in the same cycle with the occupancy unchanged; when full, gnt_o=0 even if a pop occurs that cycle.
REQ-026 SHALL hold Q, r_id_o and r_aux_o at 0 when the FIFO is empty.

Reset
REQ-027 SHALL, with RSTN=1 at an edge, empty the FIFO (r_valid_o=0, Q/r_id_o/r_aux_o=0), load the LFSR with 16'hACE1 and drive gnt_o=1 in the first cycle after reset; memory contents are not reset; requests or pending responses in flight are discarded.

Configuration
REQ-028 SHALL, with macro L2_SPRAM_RANDOM_STALL_EN defined, step a 16-bit Fibonacci LFSR (taps 16,14,13,11) every cycle and set stall = (lfsr[1:0]==2'b00); without the macro, stall is constant 0 and the LFSR is not built.

Structure
REQ-029 SHALL take from package l2_spram_pkg: LFSR seed, LFSR taps, FIFO_DEPTH default and a response struct typedef {data, id, aux}.
REQ-030 SHALL implement the response queue as one sub-module, l2_spram_resp_fifo (parameterised depth, push/pop, full/empty).

Verification
REQ-031 SHALL cover: store A=0x10 D=0xDEADBEEF BE=4'hF id=2 aux=5, then load A=0x10 -> first response Q=0/id=2/aux=5, second response Q=0xDEADBEEF.
REQ-032 SHALL cover: store BE=4'b0011 D=0x12345678 over 0xFFFFFFFF -> load returns 0xFFFF5678.
REQ-033 SHALL cover, macro off: r_gnt_i=0 with 5 back-to-back loads -> 4 granted, gnt_o=0 on the 5th; r_gnt_i=1 for one cycle -> one pop, gnt_o=1 the next cycle.
REQ-034 SHALL cover: an address above the depth, e.g. A=0x1000_0010 -> aliases to word 4, same data as A=0x10.
REQ-035 SHALL cover: RSTN=1 asserted with 3 pending responses -> r_valid_o=0 next cycle; the memory word written earlier survives.
REQ-036 SHALL cover, macro on: 1000 cycles of continuous requests -> gnt_o low in about 25% of cycles and no response is lost or reordered.
